// File: rtl/adc_sampler_pkg.sv
// Shared constants and FSM encoding for the ADC sampler.
// The default timing constants are also used by the ControlPID integration bench.
package adc_sampler_pkg;

  localparam int ADC_WIDTH = 12;

  localparam int DEF_SAMPLE_PERIOD = 64;
  localparam int DEF_SCLK_HALF     = 1;
  localparam int DEF_LEAD_BITS     = 4;
  localparam int DEF_STROBE_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_STROBE
  } adc_state_e;

endpackage

// File: rtl/adc_sampler_sample_timer.sv
// Sampling-period counter.
// Emits a registered one-cycle tick every SAMPLE_PERIOD enabled cycles.
module sample_timer
  import adc_sampler_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic clk_i,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;

  // Dropping en_i parks the counter at 0, so the first tick after
  // re-enabling is always a full period away.
  always_comb begin
    count_d = '0;
    if (en_i && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
    tick_d = en_i && (count_q == LAST);
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/adc_sampler.sv
// Periodic serial ADC reader feeding ControlPID.
// Each tick runs one cs_n/sclk frame and strobes the 12-bit result on y_k_o/dataf_o.
module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int SCLK_HALF     = DEF_SCLK_HALF,
  parameter int LEAD_BITS     = DEF_LEAD_BITS,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic                 adc_sdo_i,
  output logic                 adc_cs_n_o,
  output logic                 adc_sclk_o,
  output logic [ADC_WIDTH-1:0] y_k_o,
  output logic                 dataf_o,
  output logic                 overrun_o
);

  localparam int FRAME_BITS = LEAD_BITS + ADC_WIDTH;
  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int SW = $clog2(STROBE_CYCLES + 1);

  localparam logic [HW-1:0] HALF_LAST   = HW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_DONE    = BW'(FRAME_BITS);
  localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYCLES - 1);

  logic tick;

  sample_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk_i (clk_i),
    .reset (reset),
    .en_i  (en_i),
    .tick_o(tick)
  );

  adc_state_e           state_q, state_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic [HW-1:0]        half_q, half_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [ADC_WIDTH-1:0] shift_q, shift_d;
  logic [ADC_WIDTH-1:0] y_q, y_d;
  logic                 dataf_q, dataf_d;
  logic [SW-1:0]        strobe_q, strobe_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    half_d    = half_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    y_d       = y_q;
    dataf_d   = dataf_q;
    strobe_d  = strobe_q;
    // A tick that finds a frame in flight is dropped, only flagged.
    overrun_d = overrun_q | (tick && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SETUP;
          cs_n_d  = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d = ST_SHIFT;
        sclk_d  = 1'b1;
        half_d  = '0;
        bit_d   = '0;
        shift_d = '0;
      end
      ST_SHIFT: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (sclk_q) begin
            // Falling sclk edge: ADC data is still stable, capture it.
            // Lead bits fall off the top of the 12-bit register.
            sclk_d  = 1'b0;
            shift_d = {shift_q[ADC_WIDTH-2:0], adc_sdo_i};
            bit_d   = bit_q + BW'(1);
          end else if (bit_q == BIT_DONE) begin
            state_d = ST_HOLD;
            cs_n_d  = 1'b1;
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      ST_HOLD: begin
        state_d  = ST_STROBE;
        y_d      = shift_q;
        dataf_d  = 1'b1;
        strobe_d = '0;
      end
      ST_STROBE: begin
        if (strobe_q == STROBE_LAST) begin
          state_d = ST_IDLE;
          dataf_d = 1'b0;
        end else begin
          strobe_d = strobe_q + SW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        dataf_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      half_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      y_q       <= '0;
      dataf_q   <= 1'b0;
      strobe_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      y_q       <= y_d;
      dataf_q   <= dataf_d;
      strobe_q  <= strobe_d;
      overrun_q <= overrun_d;
    end
  end

  assign adc_cs_n_o = cs_n_q;
  assign adc_sclk_o = sclk_q;
  assign y_k_o      = y_q;
  assign dataf_o    = dataf_q;
  assign overrun_o  = overrun_q;

endmodule
